// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared FSM state encoding and master index constants for the WISHBONE arbiter
package wb_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
  localparam int BMC   = 0;
  localparam int SPIC  = 1;
  localparam int PCIEC = 2;
endpackage

// File: rtl/wb_rr_arbiter_rr_priority_select.sv
// rr_priority_select: rotate-and-find-first request picker starting one above the last winner
module rr_priority_select #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // walk offsets from farthest to nearest so the nearest requester above last wins
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin WISHBONE classic arbiter; optional bus watchdog via WB_RR_ARBITER_TIMEOUT_EN
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADR_WIDTH      = 22,
  parameter int DAT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel_i,
  output logic [DAT_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [NUM_MASTERS-1:0]           m_rty_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [ADR_WIDTH-1:0]             s_adr_o,
  output logic [DAT_WIDTH-1:0]             s_dat_o,
  output logic [DAT_WIDTH/8-1:0]           s_sel_o,
  input  logic [DAT_WIDTH-1:0]             s_dat_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  input  logic                             s_rty_i,
  output logic [NUM_MASTERS-1:0]           grant_o,
  output logic                             timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DAT_WIDTH / 8;
  state_t state, state_nx;
  logic [IW-1:0] idx, last, sel_idx;
  logic [NUM_MASTERS-1:0] sel_gnt;
  logic own, term, stall, force_term;
  rr_priority_select #(.N(NUM_MASTERS), .IW(IW)) u_sel (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (sel_gnt),
    .idx  (sel_idx)
  );
  assign own   = state == OWN;
  assign term  = s_ack_i | s_err_i | s_rty_i;
  assign stall = own & m_cyc_i[idx] & m_stb_i[idx] & ~term;
  // owner and rotation pointer are latched on the IDLE decision and held for the whole cycle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state   <= IDLE;
      grant_o <= '0;
      idx     <= '0;
      last    <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      if (!own && |m_cyc_i) begin
        grant_o <= sel_gnt;
        idx     <= sel_idx;
        last    <= sel_idx;
      end else if (own && !m_cyc_i[idx]) grant_o <= '0;
    end
  // leave OWN only when the owner drops cyc; no preemption
  always_comb state_nx = own ? (m_cyc_i[idx] ? OWN : IDLE) : (|m_cyc_i ? OWN : IDLE);
  // slave side is a mux of the owner, master side is the slave masked by the grant
  always_comb begin
    s_cyc_o   = own & m_cyc_i[idx];
    s_stb_o   = own & m_stb_i[idx] & ~force_term;
    s_we_o    = own & m_we_i[idx];
    s_adr_o   = m_adr_i[int'(idx)*ADR_WIDTH +: ADR_WIDTH];
    s_dat_o   = m_dat_i[int'(idx)*DAT_WIDTH +: DAT_WIDTH];
    s_sel_o   = m_sel_i[int'(idx)*SW +: SW];
    m_dat_o   = s_dat_i;
    m_ack_o   = grant_o & {NUM_MASTERS{s_ack_i}};
    m_err_o   = grant_o & {NUM_MASTERS{s_err_i | force_term}};
    m_rty_o   = grant_o & {NUM_MASTERS{s_rty_i}};
    timeout_o = force_term;
  end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign force_term = stall & (cnt == CW'(TIMEOUT_CYCLES - 1));
  // count stalled strobe cycles; any termination, strobe gap, idle or forced err restarts it
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else cnt <= (stall & ~force_term) ? cnt + 1'b1 : '0;
`else
  logic unused_cfg;
  assign unused_cfg = stall ^ (TIMEOUT_CYCLES != 0);
  assign force_term = 1'b0;
`endif
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;
  localparam int N = 3, AW = 22, DW = 32, SW = 4, TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [DW-1:0] m_dat_o, s_dat_i = '0, s_dat_o;
  logic [N-1:0] m_ack, m_err, m_rty, grant;
  logic s_cyc, s_stb, s_we, s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0, timeout;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  int checks = 0, errors = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input int m, input logic on);
    m_cyc[m] = on;
    m_stb[m] = on;
  endtask

  initial begin
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_timeout", timeout, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_cyc = 3'b111; m_stb = 3'b111;
    #1 chk("idle_scyc", s_cyc, 0);
    tick();
    chk("first_grant", grant, 3'b1 << BMC);
    chk("first_scyc", s_cyc, 1);
    req(BMC, 0);
    #1 chk("drop_scyc", s_cyc, 0);
    tick();
    chk("handoff_idle", grant, 0);
    tick();
    chk("grant_spic", grant, 3'b1 << SPIC);
    req(SPIC, 0);
    tick();
    chk("handoff_idle2", grant, 0);
    tick();
    chk("grant_pciec", grant, 3'b1 << PCIEC);
    req(PCIEC, 0);
    tick(); tick();
    chk("all_idle", grant, 0);

    req(SPIC, 1); m_we[SPIC] = 1'b1;
    m_adr[SPIC*AW +: AW] = 22'h000123;
    m_dat[SPIC*DW +: DW] = 32'hDEADBEEF;
    m_sel[SPIC*SW +: SW] = 4'hF;
    m_adr[BMC*AW +: AW] = 22'h3FFFFF;
    m_dat[BMC*DW +: DW] = 32'h11111111;
    tick();
    chk("wr_grant", grant, 3'b010);
    chk("wr_adr", s_adr, 22'h000123);
    chk("wr_dat", s_dat_o, 32'hDEADBEEF);
    chk("wr_sel", s_sel, 4'hF);
    chk("wr_we", s_we, 1);
    chk("wr_stb", s_stb, 1);
    chk("wr_noack0", m_ack, 0);
    tick();
    chk("wr_noack1", m_ack, 0);
    tick();
    chk("wr_noack2", m_ack, 0);
    s_ack = 1'b1; s_dat_i = 32'hCAFEF00D;
    #1;
    chk("wr_ack", m_ack, 3'b010);
    chk("rd_dat", m_dat_o, 32'hCAFEF00D);
    chk("wr_noerr", m_err, 0);
    tick();
    s_ack = 1'b0;
    req(SPIC, 0); m_we[SPIC] = 1'b0;
    #1 chk("wr_ack_once", m_ack, 0);
    tick();

    m_cyc = 3'b101; m_stb = 3'b101;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("nopreempt_grant", grant, 3'b100);
      tick();
    end
    req(PCIEC, 0);
    tick();
    chk("np_gap_scyc", s_cyc, 0);
    chk("np_gap_grant", grant, 0);
    tick();
    chk("np_m0_scyc", s_cyc, 1);
    chk("np_m0_grant", grant, 3'b001);
    chk("np_m0_adr", s_adr, 22'h3FFFFF);

    req(BMC, 0);
    #1 chk("abandon_scyc", s_cyc, 0);
    tick();
    s_ack = 1'b1;
    #1 chk("abandon_noack", m_ack, 0);
    tick();
    s_ack = 1'b0;

    req(SPIC, 1);
    tick();
    chk("stall_grant", grant, 3'b010);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      chk("to_quiet", timeout, 0);
      tick();
    end
    chk("to_pulse", timeout, 1);
    chk("to_err", m_err, 3'b010);
    chk("to_stb", s_stb, 0);
    tick();
    chk("to_once", timeout, 0);
    chk("to_stb_back", s_stb, 1);
    req(SPIC, 0);
    tick();
    req(PCIEC, 1);
    tick();
    chk("race_grant", grant, 3'b100);
    for (int c = 1; c < TO; c++) tick();
    s_ack = 1'b1;
    #1;
    chk("race_ack", m_ack, 3'b100);
    chk("race_noerr", m_err, 0);
    chk("race_notimeout", timeout, 0);
    chk("race_stb", s_stb, 1);
    tick();
    s_ack = 1'b0;
    req(PCIEC, 0);
    tick();
`else
    for (int c = 0; c < 20; c++) tick();
    chk("hang_noerr", m_err, 0);
    chk("hang_notimeout", timeout, 0);
    chk("hang_stb", s_stb, 1);
    req(SPIC, 0);
    tick();
    req(PCIEC, 1);
    tick();
    chk("hang_next_grant", grant, 3'b100);
    req(PCIEC, 0);
    tick();
`endif
    tick();

    req(SPIC, 1);
    tick();
    chk("ar_grant_before", grant, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_scyc", s_cyc, 0);
    req(BMC, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_next_grant", grant, 3'b001);
    m_cyc = '0; m_stb = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end
endmodule
